// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - even/odd banked byte RAM with unaligned 16-bit access; optional clear sequencer under RAM_CLEAR_EN
module byte_ram #(
    parameter int          SIZEBITS = 10,
    parameter int unsigned TOP      = 32'h4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_en,
    input  logic [15:0] rd_addr,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic [1:0]  wr_en,
    output logic        busy
);

    localparam int          IW    = SIZEBITS - 1;
    localparam int          DEPTH = 2 ** IW;
    localparam logic [16:0] SPAN  = 17'(2 ** SIZEBITS);
    localparam logic [15:0] BASE  = 16'(TOP - 2 ** SIZEBITS);

    // Window offset wraps modulo 2**16, so anything below BASE lands far above SPAN.
    function automatic logic in_window(input logic [15:0] a);
        return ({1'b0, 16'(a - BASE)} < SPAN);
    endfunction

    // Bank index drops bit 0 of the window offset; bit 0 of the address picks the bank.
    function automatic logic [IW-1:0] bank_index(input logic [15:0] a);
        return IW'((a - BASE) >> 1);
    endfunction

    // ------------------------------------------------------------------
    // Address split: the two bytes of any access fall into opposite banks
    // ------------------------------------------------------------------
    logic [15:0] rd_hi_addr;
    logic [15:0] wr_hi_addr;
    logic [15:0] rd_ev_addr;
    logic [15:0] rd_od_addr;
    logic [15:0] wr_ev_addr;
    logic [15:0] wr_od_addr;

    assign rd_hi_addr = rd_addr + 16'd1;
    assign wr_hi_addr = wr_addr + 16'd1;
    assign rd_ev_addr = rd_addr[0] ? rd_hi_addr : rd_addr;
    assign rd_od_addr = rd_addr[0] ? rd_addr    : rd_hi_addr;
    assign wr_ev_addr = wr_addr[0] ? wr_hi_addr : wr_addr;
    assign wr_od_addr = wr_addr[0] ? wr_addr    : wr_hi_addr;

    logic          rd_ev_win;
    logic          rd_od_win;
    logic          wr_ev_win;
    logic          wr_od_win;
    logic [IW-1:0] rd_ev_idx;
    logic [IW-1:0] rd_od_idx;
    logic [IW-1:0] wr_ev_idx;
    logic [IW-1:0] wr_od_idx;

    assign rd_ev_win = in_window(rd_ev_addr);
    assign rd_od_win = in_window(rd_od_addr);
    assign wr_ev_win = in_window(wr_ev_addr);
    assign wr_od_win = in_window(wr_od_addr);
    assign rd_ev_idx = bank_index(rd_ev_addr);
    assign rd_od_idx = bank_index(rd_od_addr);
    assign wr_ev_idx = bank_index(wr_ev_addr);
    assign wr_od_idx = bank_index(wr_od_addr);

    // Write lane steering: an odd base address sends the high lane to the even bank.
    logic       wr_ev_lane_en;
    logic       wr_od_lane_en;
    logic [7:0] wr_ev_byte;
    logic [7:0] wr_od_byte;

    assign wr_ev_lane_en = wr_addr[0] ? wr_en[1]       : wr_en[0];
    assign wr_od_lane_en = wr_addr[0] ? wr_en[0]       : wr_en[1];
    assign wr_ev_byte    = wr_addr[0] ? wr_data[15:8]  : wr_data[7:0];
    assign wr_od_byte    = wr_addr[0] ? wr_data[7:0]   : wr_data[15:8];

    // ------------------------------------------------------------------
    // Acceptance and optional clear sequencer
    // ------------------------------------------------------------------
    logic          rd_acc;
    logic          wr_acc;
    logic          clr_active;
    logic [IW-1:0] clr_idx;

`ifdef RAM_CLEAR_EN
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t        state_q;
    logic [IW-1:0] clr_idx_q;
    logic          busy_q;

    // Clear sequencer: sweep every bank index once after reset, then idle in READY
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == IW'(DEPTH - 1)) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end
                end
                READY: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= CLEAR;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign clr_active = (state_q == CLEAR);
    assign clr_idx    = clr_idx_q;
`else
    assign busy       = 1'b0;
    assign clr_active = 1'b0;
    assign clr_idx    = '0;
`endif

    assign rd_acc = rd_en & ~busy;
    assign wr_acc = ~busy;

    logic user_ev_we;
    logic user_od_we;

    assign user_ev_we = wr_acc & wr_ev_lane_en & wr_ev_win;
    assign user_od_we = wr_acc & wr_od_lane_en & wr_od_win;

    // Bank write ports: the clear sweep owns both ports while it runs.
    logic          ev_we;
    logic          od_we;
    logic [IW-1:0] ev_widx;
    logic [IW-1:0] od_widx;
    logic [7:0]    ev_wbyte;
    logic [7:0]    od_wbyte;

    assign ev_we    = clr_active | user_ev_we;
    assign od_we    = clr_active | user_od_we;
    assign ev_widx  = clr_active ? clr_idx : wr_ev_idx;
    assign od_widx  = clr_active ? clr_idx : wr_od_idx;
    assign ev_wbyte = clr_active ? 8'h00   : wr_ev_byte;
    assign od_wbyte = clr_active ? 8'h00   : wr_od_byte;

    // ------------------------------------------------------------------
    // Banks: single write port, registered read (read-before-write)
    // ------------------------------------------------------------------
    logic [7:0] mem_ev [DEPTH];
    logic [7:0] mem_od [DEPTH];
    logic [7:0] ev_rbyte_q;
    logic [7:0] od_rbyte_q;

    // Even bank; read register only loads on an accepted read so rd_data holds otherwise
    always_ff @(posedge clk) begin
        if (ev_we) begin
            mem_ev[ev_widx] <= ev_wbyte;
        end
        if (rd_acc) begin
            ev_rbyte_q <= mem_ev[rd_ev_idx];
        end
    end

    // Odd bank; same structure as the even bank
    always_ff @(posedge clk) begin
        if (od_we) begin
            mem_od[od_widx] <= od_wbyte;
        end
        if (rd_acc) begin
            od_rbyte_q <= mem_od[rd_od_idx];
        end
    end

    // ------------------------------------------------------------------
    // Read-side bookkeeping: lane, window and same-cycle forwarding
    // ------------------------------------------------------------------
    logic       ev_fwd_d;
    logic       od_fwd_d;
    logic       rd_valid_q;
    logic       lane_q;
    logic       ev_ok_q;
    logic       od_ok_q;
    logic       ev_fwd_q;
    logic       od_fwd_q;
    logic [7:0] ev_fwd_byte_q;
    logic [7:0] od_fwd_byte_q;

    // The bank returns old data on a same-index write, so the new byte is captured beside it.
    assign ev_fwd_d = user_ev_we & rd_ev_win & (wr_ev_idx == rd_ev_idx);
    assign od_fwd_d = user_od_we & rd_od_win & (wr_od_idx == rd_od_idx);

    // Capture steering/masking state of each accepted read; reset zeroes the visible result
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q    <= 1'b0;
            lane_q        <= 1'b0;
            ev_ok_q       <= 1'b0;
            od_ok_q       <= 1'b0;
            ev_fwd_q      <= 1'b0;
            od_fwd_q      <= 1'b0;
            ev_fwd_byte_q <= 8'h00;
            od_fwd_byte_q <= 8'h00;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                lane_q        <= rd_addr[0];
                ev_ok_q       <= rd_ev_win;
                od_ok_q       <= rd_od_win;
                ev_fwd_q      <= ev_fwd_d;
                od_fwd_q      <= od_fwd_d;
                ev_fwd_byte_q <= wr_ev_byte;
                od_fwd_byte_q <= wr_od_byte;
            end
        end
    end

    logic [7:0] ev_byte;
    logic [7:0] od_byte;

    // Output lanes: out-of-window bytes read as zero, lane order from the registered address bit
    always_comb begin
        ev_byte = 8'h00;
        od_byte = 8'h00;
        if (ev_ok_q) begin
            ev_byte = ev_fwd_q ? ev_fwd_byte_q : ev_rbyte_q;
        end
        if (od_ok_q) begin
            od_byte = od_fwd_q ? od_fwd_byte_q : od_rbyte_q;
        end
    end

    assign rd_data  = lane_q ? {ev_byte, od_byte} : {od_byte, ev_byte};
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_byte_ram.sv
// tb/tb_byte_ram.sv - randomized self-checking bench for byte_ram against a byte-array model
module tb_byte_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_en;
    logic        busy;

    always #5 clk = ~clk;

    byte_ram #(
        .SIZEBITS(10),
        .TOP     (32'h4000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .busy    (busy)
    );

    logic [7:0]  model [0:65535];
    logic [15:0] held;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic in_win(input logic [15:0] a);
        return (a >= 16'h3C00) && (a <= 16'h3FFF);
    endfunction

    function automatic logic [7:0] mread(input logic [15:0] a);
        return in_win(a) ? model[a] : 8'h00;
    endfunction

    // Byte seen by a read at address a when a write (wa, we, wd) happens in the same cycle.
    function automatic logic [7:0] seen(input logic [15:0] a, input logic [15:0] wa,
                                        input logic [1:0] we, input logic [15:0] wd);
        logic [15:0] w1;
        w1 = wa + 16'd1;
        if (!in_win(a))          return 8'h00;
        if (we[0] && a == wa)    return wd[7:0];
        if (we[1] && a == w1)    return wd[15:8];
        return model[a];
    endfunction

    // One cycle: drive at negedge, update model, check result at the next negedge.
    task automatic cyc(input logic re, input logic [15:0] ra, input logic [1:0] we,
                       input logic [15:0] wa, input logic [15:0] wd, input string tag);
        logic [15:0] r1;
        logic [15:0] w1;
        logic [15:0] exp;
        r1 = ra + 16'd1;
        w1 = wa + 16'd1;
        rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd;
        exp = {seen(r1, wa, we, wd), seen(ra, wa, we, wd)};
        if (we[0] && in_win(wa)) model[wa] = wd[7:0];
        if (we[1] && in_win(w1)) model[w1] = wd[15:8];
        @(posedge clk);
        @(negedge clk);
        if (re) held = exp;
        check({tag, ".valid"}, {31'd0, rd_valid}, {31'd0, re});
        check({tag, ".data"}, {16'd0, rd_data}, {16'd0, held});
        rd_en = 1'b0; wr_en = 2'b00;
    endtask

    task automatic pulse_reset();
        rd_en = 1'b0; wr_en = 2'b00;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        held  = 16'h0000;
    endtask

    // Counts cycles with busy high while hammering stray reads and writes that must be ignored.
    task automatic count_busy(input int limit, output int n);
        n = 0;
        while (busy === 1'b1 && n < limit) begin
            rd_en   = 1'b1;
            rd_addr = 16'h3C00 + 16'($urandom_range(0, 1023));
            wr_en   = 2'b11;
            wr_addr = 16'h3C00 + 16'($urandom_range(0, 1023));
            wr_data = 16'hFFFF;
            @(posedge clk);
            @(negedge clk);
            n++;
            if (rd_valid !== 1'b0) check("clr.valid", {31'd0, rd_valid}, 32'd0);
        end
        rd_en = 1'b0; wr_en = 2'b00;
    endtask

    initial begin
        int n;
        logic [15:0] ra;
        logic [15:0] wa;
        held = 16'h0000;
        reset = 1'b1; rd_en = 1'b1; rd_addr = 16'h3C00;
        wr_en = 2'b00; wr_addr = 16'h0000; wr_data = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst.valid", {31'd0, rd_valid}, 32'd0);
        check("rst.data", {16'd0, rd_data}, 32'd0);
`ifdef RAM_CLEAR_EN
        check("rst.busy", {31'd0, busy}, 32'd1);
        reset = 1'b0; rd_en = 1'b0;
        count_busy(2000, n);
        check("clr.first", n, 512);
        for (int a = 16'h3C00; a <= 16'h3FFF; a++) model[a] = 8'h00;
        for (int a = 16'h3C00; a <= 16'h3FFF; a += 2)
            cyc(1'b0, 16'h0, 2'b11, 16'(a), 16'hFFFF, "fill");
        cyc(1'b1, 16'h3C10, 2'b00, 16'h0, 16'h0, "fillchk");
        check("fill.ff", {16'd0, rd_data}, 32'h0000FFFF);
        pulse_reset();
        count_busy(2000, n);
        check("clr.cycles", n, 512);
        for (int a = 16'h3C00; a <= 16'h3FFF; a++) model[a] = 8'h00;
        for (int a = 16'h3C00; a <= 16'h3FFF; a += 2)
            cyc(1'b1, 16'(a), 2'b00, 16'h0, 16'h0, "clr.zero");
        for (int a = 16'h3C00; a <= 16'h3FFF; a += 2)
            cyc(1'b0, 16'h0, 2'b11, 16'(a), 16'hFFFF, "fill2");
        pulse_reset();
        count_busy(200, n);
        check("mid.count", n, 200);
        check("mid.busy", {31'd0, busy}, 32'd1);
        pulse_reset();
        count_busy(2000, n);
        check("restart.cycles", n, 512);
        for (int a = 16'h3C00; a <= 16'h3FFF; a++) model[a] = 8'h00;
        for (int a = 16'h3C01; a <= 16'h3FFF; a += 2)
            cyc(1'b1, 16'(a), 2'b00, 16'h0, 16'h0, "restart.zero");
`else
        check("rst.busy", {31'd0, busy}, 32'd0);
        reset = 1'b0; rd_en = 1'b0;
        for (int a = 16'h3C00; a <= 16'h3FFF; a += 2)
            cyc(1'b0, 16'h0, 2'b11, 16'(a), 16'h0000, "init");
`endif
        // Directed vectors
        cyc(1'b0, 16'h0, 2'b11, 16'h3C00, 16'hBEEF, "aln.w");
        cyc(1'b1, 16'h3C00, 2'b00, 16'h0, 16'h0, "aln.r");
        check("aln.const", {16'd0, rd_data}, 32'h0000BEEF);
        cyc(1'b0, 16'h0, 2'b01, 16'h3C01, 16'h1234, "una.w");
        cyc(1'b1, 16'h3C00, 2'b00, 16'h0, 16'h0, "una.r0");
        check("una.const0", {16'd0, rd_data}, 32'h000034EF);
        cyc(1'b1, 16'h3C01, 2'b00, 16'h0, 16'h0, "una.r1");
        check("una.const1", {16'd0, rd_data}, 32'h00000034);
        cyc(1'b0, 16'h0, 2'b11, 16'h3D02, 16'h9900, "col.pre");
        cyc(1'b1, 16'h3D03, 2'b10, 16'h3D03, 16'hA55A, "col");
        check("col.const", {16'd0, rd_data}, 32'h0000A599);
        cyc(1'b0, 16'h0, 2'b11, 16'h3FFF, 16'h7766, "edge.w");
        cyc(1'b1, 16'h3FFF, 2'b00, 16'h0, 16'h0, "edge.top");
        check("edge.top.const", {16'd0, rd_data}, 32'h00000066);
        cyc(1'b1, 16'h3BFF, 2'b00, 16'h0, 16'h0, "edge.bot");
        check("edge.bot.const", {16'd0, rd_data}, 32'h0000EF00);
        cyc(1'b0, 16'h3C00, 2'b00, 16'h0, 16'h0, "hold");
        check("hold.const", {16'd0, rd_data}, 32'h0000EF00);
        cyc(1'b1, 16'hFFFF, 2'b11, 16'hFFFF, 16'hCAFE, "wrap");
        check("wrap.const", {16'd0, rd_data}, 32'h00000000);

`ifndef RAM_CLEAR_EN
        // Reset discards a pending read but keeps memory contents
        rd_en = 1'b1; rd_addr = 16'h3C00; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst2.valid", {31'd0, rd_valid}, 32'd0);
        check("rst2.data", {16'd0, rd_data}, 32'd0);
        reset = 1'b0; rd_en = 1'b0; held = 16'h0000;
        cyc(1'b1, 16'h3C00, 2'b00, 16'h0, 16'h0, "rst2.keep");
        check("rst2.keep.const", {16'd0, rd_data}, 32'h000034EF);
`endif

        // Randomized traffic clustered around the window edges, with frequent collisions
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 16'($urandom);
                1:       ra = 16'($urandom_range(32'h3BF8, 32'h3C08));
                2:       ra = 16'($urandom_range(32'h3FF8, 32'h4008));
                default: ra = 16'($urandom_range(32'h3C00, 32'h3FFF));
            endcase
            if ($urandom_range(0, 1) == 0)
                wa = ra + 16'($urandom_range(0, 2)) - 16'd1;
            else
                wa = 16'($urandom_range(32'h3BF8, 32'h4008));
            cyc(1'($urandom_range(0, 3) != 0), ra, 2'($urandom), wa, 16'($urandom), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
